// File: rtl/accum_nbit.sv
// Vector-sum reduction stage: accumulates a programmed number of stream
// operands through an adder_nbit feedback loop and presents the total.

module adder_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum
);
  // Carry-out is dropped; the sum wraps modulo 2^WIDTH.
  assign Sum = A + B;
endmodule

module accum_nbit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]     sum;

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .A   (acc_q),
    .B   (in_data),
    .Sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // A start coinciding with this exit is deliberately not seen.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on registered state.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;

endmodule

// File: tb/tb_accum_nbit.sv
// Randomized self-checking bench for accum_nbit against a plain-sum model.

module tb_accum_nbit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  logic        s8_start = 1'b0;
  logic [7:0]  s8_len = '0;
  logic        s8_in_valid = 1'b0;
  logic        s8_in_ready;
  logic [7:0]  s8_in_data = '0;
  logic        s8_out_valid;
  logic        s8_out_ready = 1'b0;
  logic [7:0]  s8_out_data;
  logic        s8_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] vals [0:255];

  always #5 clk = ~clk;

  accum_nbit #(.WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  accum_nbit #(.WIDTH(8), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .len(s8_len),
    .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_data(s8_in_data),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready), .out_data(s8_out_data),
    .busy(s8_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gap < 0 picks a random bubble count per beat; ign injects starts that must be ignored.
  task automatic do_run(input int n, input int gap, input bit bp_en, input bit ign);
    logic [31:0] exp_sum;
    int g;
    exp_sum = '0;
    for (int i = 0; i < n; i++) exp_sum = exp_sum + vals[i];

    check_eq("idle_busy", {63'd0, busy}, 64'd0);
    check_eq("idle_in_ready", {63'd0, in_ready}, 64'd0);
    start = 1'b1;
    len   = n[7:0];
    tick;
    start = 1'b0;
    len   = 8'($urandom);
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);

    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        check_eq("gap_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("gap_out_valid", {63'd0, out_valid}, 64'd0);
        tick;
      end
      in_valid = 1'b1;
      in_data  = vals[i];
      if (ign && i == 1) begin
        start = 1'b1;
        len   = 8'd9;
      end
      check_eq("beat_in_ready", {63'd0, in_ready}, 64'd1);
      tick;
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = $urandom;
    end

    check_eq("done_out_valid", {63'd0, out_valid}, 64'd1);
    check_eq("done_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("done_busy", {63'd0, busy}, 64'd1);
    check_eq("done_sum", {32'd0, out_data}, {32'd0, exp_sum});

    if (bp_en) begin
      repeat (int'($urandom_range(1, 5))) begin
        out_ready = 1'b0;
        start     = ign;
        len       = 8'd9;
        in_valid  = 1'b1;
        tick;
        start    = 1'b0;
        in_valid = 1'b0;
        check_eq("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check_eq("bp_sum_stable", {32'd0, out_data}, {32'd0, exp_sum});
      end
    end

    out_ready = 1'b1;
    start     = ign;
    len       = 8'd9;
    tick;
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq("exit_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("exit_busy", {63'd0, busy}, 64'd0);
    check_eq("idle_keeps_sum", {32'd0, out_data}, {32'd0, exp_sum});
    tick;
    check_eq("still_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_data", {32'd0, out_data}, 64'd0);
    rst_n = 1'b1;
    tick;

    // 8-bit wrap-around: FF + 02 = 01
    s8_start = 1'b1; s8_len = 8'd2;
    tick;
    s8_start = 1'b0;
    s8_in_valid = 1'b1; s8_in_data = 8'hFF;
    tick;
    s8_in_data = 8'h02;
    tick;
    s8_in_valid = 1'b0;
    check_eq("w8_out_valid", {63'd0, s8_out_valid}, 64'd1);
    check_eq("w8_in_ready", {63'd0, s8_in_ready}, 64'd0);
    check_eq("w8_sum", {56'd0, s8_out_data}, 64'h01);
    s8_out_ready = 1'b1;
    tick;
    s8_out_ready = 1'b0;
    check_eq("w8_busy", {63'd0, s8_busy}, 64'd0);

    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    do_run(4, 0, 1'b0, 1'b0);

    vals[0] = 5; vals[1] = 0; vals[2] = 7;
    do_run(3, 3, 1'b1, 1'b0);

    do_run(0, 0, 1'b1, 1'b1);

    vals[0] = 10; vals[1] = 20;
    do_run(2, 1, 1'b1, 1'b1);

    vals[0] = 32'hFFFF_FFFF; vals[1] = 32'h0000_0003;
    do_run(2, 0, 1'b0, 1'b0);

    // Reset in the middle of a run discards the partial sum.
    vals[0] = 100; vals[1] = 200;
    start = 1'b1; len = 8'd4;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_out_data", {32'd0, out_data}, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    vals[0] = 7;
    do_run(1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) vals[i] = $urandom;
      do_run(n, -1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, limit reached");
    $fatal(1, "timeout");
  end

endmodule
